// File: rtl/tx_arb_pkg.sv
// Shared state encoding and helpers for the Tx frame arbiter.
package tx_arb_pkg;

  localparam int unsigned TX_DATA_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } tx_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem != 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot pick of the first request at or after ptr_i.
module rr_picker
  import tx_arb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic             valid_o
);

  // Search upward from the pointer, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter sharing one Tx beat path between N frame sources; the grant is held for a whole frame.
// Optional stall timeout with timeout_o pulse: define TX_FRAME_ARBITER_TIMEOUT_EN.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned N_SOURCES      = 3,
  parameter int unsigned DATA_WIDTH     = TX_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_SOURCES*DATA_WIDTH-1:0] src_data,
  input  logic [N_SOURCES-1:0]            src_rdy,
  input  logic [N_SOURCES-1:0]            src_eof,
  output logic [N_SOURCES-1:0]            src_ack,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_rdy,
  output logic                            tx_eof,
  input  logic                            tx_ack,
  output logic [N_SOURCES-1:0]            grant,
  output logic                            busy
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
  ,
  output logic                            timeout_o
`endif
);

  localparam int unsigned PTR_W = clog2(N_SOURCES);

  if (N_SOURCES < 2 || N_SOURCES > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("tx_frame_arbiter: N_SOURCES must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  tx_state_e            state_q;
  logic [N_SOURCES-1:0] grant_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [N_SOURCES-1:0] pick;
  logic                 pick_vld;
  logic [PTR_W-1:0]     next_ptr;
  logic                 xfer;
  logic                 frame_done;

  rr_picker #(
    .N     (N_SOURCES),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i   (src_rdy),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  // Output mux from the owner; grant_q is zero in IDLE so everything falls to 0 there.
  always_comb begin
    tx_data  = '0;
    tx_rdy   = 1'b0;
    tx_eof   = 1'b0;
    src_ack  = '0;
    next_ptr = '0;
    for (int unsigned i = 0; i < N_SOURCES; i++) begin
      if (grant_q[i]) begin
        tx_data    = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        tx_rdy     = src_rdy[i];
        tx_eof     = src_eof[i];
        src_ack[i] = tx_ack && src_rdy[i];
        next_ptr   = PTR_W'((i + 1) % N_SOURCES);
      end
    end
  end

  assign xfer  = tx_rdy && tx_ack;
  assign grant = grant_q;
  assign busy  = (state_q == ST_BUSY);

`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
  localparam int unsigned TMO_W = clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;
  logic             tmo_hit;

  // Fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign tmo_hit   = busy && !tx_rdy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk) begin
    if (rst || !busy || xfer || tmo_hit) begin
      tmo_cnt_q <= '0;
    end else if (!tx_rdy) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
    timeout_q <= !rst && tmo_hit;
  end

  assign frame_done = (xfer && tx_eof) || tmo_hit;
`else
  assign frame_done = xfer && tx_eof;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q <= pick;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (frame_done) begin
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: directed scenarios plus a randomized run against a frame-level reference model.
module tb_tx_frame_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_rdy;
  logic [N-1:0]    src_eof;
  logic [N-1:0]    src_ack;
  logic [DW-1:0]   tx_data;
  logic            tx_rdy;
  logic            tx_eof;
  logic            tx_ack;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
  logic            timeout_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tx_frame_arbiter #(
    .N_SOURCES      (N),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_data (src_data),
    .src_rdy  (src_rdy),
    .src_eof  (src_eof),
    .src_ack  (src_ack),
    .tx_data  (tx_data),
    .tx_rdy   (tx_rdy),
    .tx_eof   (tx_eof),
    .tx_ack   (tx_ack),
    .grant    (grant),
    .busy     (busy)
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
    ,
    .timeout_o (timeout_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic rdy, input logic [DW-1:0] d, input logic eof);
    src_rdy[i]            = rdy;
    src_eof[i]            = eof;
    src_data[i*DW +: DW]  = d;
  endtask

  task automatic idle_inputs();
    src_rdy  = '0;
    src_eof  = '0;
    src_data = '0;
    tx_ack   = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({grant, busy, tx_rdy, tx_eof, tx_data, src_ack} !== '0) begin
      errors++;
      $display("FAIL reset_state: grant=%b busy=%b rdy=%b eof=%b data=%h ack=%b, expected all 0",
               grant, busy, tx_rdy, tx_eof, tx_data, src_ack);
    end
    rst    = 1'b0;
    tx_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      checks++;
      if ({grant, busy, tx_rdy, tx_eof, tx_data, src_ack} !== '0) begin
        errors++;
        $display("FAIL idle_cycle%0d: grant=%b busy=%b rdy=%b ack=%b, expected all 0",
                 c, grant, busy, tx_rdy, src_ack);
      end
    end
    tx_ack = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d;
    set_src(1, 1'b1, 8'hA1, 1'b0);
    tx_ack = 1'b1;
    #1;
    checks++;
    if (grant !== 3'b000 || tx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL single_req_cycle: grant=%b rdy=%b, expected 000 0", grant, tx_rdy);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      exp_d = 8'hA1 + DW'(b);
      if (b > 0) set_src(1, 1'b1, exp_d, b == 3);
      #1;
      checks++;
      if (grant !== 3'b010 || busy !== 1'b1 || tx_data !== exp_d || tx_eof !== (b == 3) ||
          src_ack !== 3'b010) begin
        errors++;
        $display("FAIL single_beat%0d: grant=%b busy=%b data=%h eof=%b ack=%b, expected 010 1 %h %b 010",
                 b, grant, busy, tx_data, tx_eof, src_ack, exp_d, b == 3);
      end
    end
    tick();
    set_src(1, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h10, 1'b1);
    set_src(2, 1'b1, 8'h12, 1'b1);
    #1;
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0 || src_ack !== 3'b000) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b ack=%b, expected 000 0 000", grant, busy, src_ack);
    end
    // Pointer now sits at 2, so source 2 beats source 0.
    tick();
    #1;
    checks++;
    if (grant !== 3'b100 || tx_data !== 8'h12 || src_ack !== 3'b100) begin
      errors++;
      $display("FAIL single_ptr_rot: grant=%b data=%h ack=%b, expected 100 12 100", grant, tx_data, src_ack);
    end
    tick();
    set_src(2, 1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (grant !== 3'b000 || src_ack !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_bubble: grant=%b ack=%b busy=%b, expected 000 000 0", grant, src_ack, busy);
    end
    tick();
    #1;
    checks++;
    if (grant !== 3'b001 || tx_data !== 8'h10) begin
      errors++;
      $display("FAIL single_next: grant=%b data=%h, expected 001 10", grant, tx_data);
    end
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    tx_ack = 1'b0;
  endtask

  task automatic test_contention();
    pulse_reset();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 8'(i * 16), 1'b0);
    tx_ack = 1'b1;
    for (int o = 0; o < N; o++) begin
      tick();
      for (int b = 0; b < 2; b++) begin
        if (b == 1) set_src(o, 1'b1, 8'(o * 16 + 1), 1'b1);
        #1;
        checks++;
        if (grant !== 3'(1 << o) || src_ack !== 3'(1 << o) || tx_data !== 8'(o * 16 + b) ||
            tx_eof !== (b == 1)) begin
          errors++;
          $display("FAIL contention_src%0d_beat%0d: grant=%b ack=%b data=%h eof=%b, expected %b %b %h %b",
                   o, b, grant, src_ack, tx_data, tx_eof, 3'(1 << o), 3'(1 << o), 8'(o * 16 + b), b == 1);
        end
        tick();
      end
      set_src(o, 1'b0, 8'h00, 1'b0);
      #1;
      checks++;
      if (grant !== 3'b000 || src_ack !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL contention_bubble%0d: grant=%b ack=%b busy=%b, expected 000 000 0",
                 o, grant, src_ack, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    bit            pat [4];
    int            xfers;
    logic [N-1:0]  exp_grant;
    logic [N-1:0]  exp_ack;
    logic          exp_rdy;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    xfers = 0;
    set_src(2, 1'b1, 8'h55, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tx_ack    = pat[c];
      exp_grant = (c == 0) ? 3'b000 : 3'b100;
      exp_rdy   = (c != 0);
      exp_ack   = (c != 0 && pat[c]) ? 3'b100 : 3'b000;
      #1;
      if (src_ack[2] && tx_ack) xfers++;
      checks++;
      if (grant !== exp_grant || tx_rdy !== exp_rdy || src_ack !== exp_ack ||
          tx_data !== (exp_rdy ? 8'h55 : 8'h00)) begin
        errors++;
        $display("FAIL bp_cycle%0d: grant=%b rdy=%b ack=%b data=%h, expected %b %b %b %h",
                 c, grant, tx_rdy, src_ack, tx_data, exp_grant, exp_rdy, exp_ack, exp_rdy ? 8'h55 : 8'h00);
      end
      tick();
    end
    set_src(2, 1'b0, 8'h00, 1'b0);
    tx_ack = 1'b0;
    #1;
    checks++;
    if (xfers != 1 || busy !== 1'b0 || grant !== 3'b000) begin
      errors++;
      $display("FAIL bp_once: transfers=%0d busy=%b grant=%b, expected 1 0 000", xfers, busy, grant);
    end
  endtask

  task automatic test_stall();
    set_src(0, 1'b1, 8'h31, 1'b0);
    tx_ack = 1'b1;
    tick();
    #1;
    checks++;
    if (grant !== 3'b001 || tx_data !== 8'h31) begin
      errors++;
      $display("FAIL stall_grant: grant=%b data=%h, expected 001 31", grant, tx_data);
    end
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    set_src(1, 1'b1, 8'h41, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (grant !== 3'b001 || tx_rdy !== 1'b0 || src_ack !== 3'b000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: grant=%b rdy=%b ack=%b busy=%b, expected 001 0 000 1",
                 c, grant, tx_rdy, src_ack, busy);
      end
      tick();
    end
    set_src(0, 1'b1, 8'h32, 1'b1);
    #1;
    checks++;
    if (grant !== 3'b001 || tx_data !== 8'h32 || tx_eof !== 1'b1 || src_ack !== 3'b001) begin
      errors++;
      $display("FAIL stall_resume: grant=%b data=%h eof=%b ack=%b, expected 001 32 1 001",
               grant, tx_data, tx_eof, src_ack);
    end
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    tick();
    #1;
    checks++;
    if (grant !== 3'b010 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL stall_pending_next: grant=%b data=%h, expected 010 41", grant, tx_data);
    end
    tick();
    set_src(1, 1'b0, 8'h00, 1'b0);
    tx_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    set_src(1, 1'b1, 8'h61, 1'b1);
    tx_ack = 1'b1;
    tick();
    tick();
    set_src(1, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h70, 1'b0);
    tick();
    #1;
    checks++;
    if (grant !== 3'b001 || tx_data !== 8'h70) begin
      errors++;
      $display("FAIL rstmid_grant: grant=%b data=%h, expected 001 70", grant, tx_data);
    end
    tick();
    set_src(0, 1'b1, 8'h71, 1'b0);
    tick();
    set_src(0, 1'b1, 8'h72, 1'b0);
    set_src(2, 1'b1, 8'h80, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({grant, busy, tx_rdy, tx_eof, tx_data, src_ack} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: grant=%b busy=%b rdy=%b data=%h ack=%b, expected all 0",
               grant, busy, tx_rdy, tx_data, src_ack);
    end
    tick();
    #1;
    checks++;
    if (grant !== 3'b001 || tx_data !== 8'h72) begin
      errors++;
      $display("FAIL rstmid_restart: grant=%b data=%h, expected 001 72", grant, tx_data);
    end
    pulse_reset();
  endtask

`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    pulse_reset();
    set_src(0, 1'b1, 8'h90, 1'b0);
    set_src(1, 1'b1, 8'hA0, 1'b1);
    tx_ack = 1'b1;
    tick();
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < TMO; k++) begin
      #1;
      checks++;
      if (grant !== 3'b001 || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL tmo_hold%0d: grant=%b timeout=%b, expected 001 0", k, grant, timeout_o);
      end
      tick();
    end
    #1;
    checks++;
    if (timeout_o !== 1'b1 || grant !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire: timeout=%b grant=%b busy=%b, expected 1 000 0", timeout_o, grant, busy);
    end
    tick();
    #1;
    checks++;
    if (grant !== 3'b010 || timeout_o !== 1'b0 || tx_data !== 8'hA0) begin
      errors++;
      $display("FAIL tmo_next: grant=%b timeout=%b data=%h, expected 010 0 a0", grant, timeout_o, tx_data);
    end
    tick();
    set_src(1, 1'b0, 8'h00, 1'b0);
    tx_ack = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] q_data [N][$];
    bit            q_eof  [N][$];
    bit            pres   [N];
    int            gap    [N];
    int            owner, ptr, nf, len, j;
    bit            found, eof_now, pending;
    logic [N-1:0]  exp_grant, exp_ack;
    logic          exp_busy, exp_rdy, exp_eof;
    logic [DW-1:0] exp_data;
    pulse_reset();
    owner = -1;
    ptr   = 0;
    for (int i = 0; i < N; i++) begin
      pres[i] = 1'b0;
      gap[i]  = int'($urandom_range(0, 3));
      nf      = int'($urandom_range(2, 4));
      for (int f = 0; f < nf; f++) begin
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) begin
          q_data[i].push_back(DW'($urandom));
          q_eof[i].push_back(b == len - 1);
        end
      end
    end
    pending = 1'b1;
    for (int cyc = 0; cyc < 3000 && pending; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pres[i] && q_data[i].size() > 0) begin
          if (gap[i] == 0) pres[i] = 1'b1;
          else gap[i]--;
        end
        if (pres[i]) set_src(i, 1'b1, q_data[i][0], q_eof[i][0]);
        else set_src(i, 1'b0, 8'h00, 1'b0);
      end
      tx_ack = ($urandom_range(0, 3) != 0);
      #1;
      exp_grant = '0;
      exp_ack   = '0;
      exp_busy  = (owner >= 0);
      exp_rdy   = 1'b0;
      exp_eof   = 1'b0;
      exp_data  = '0;
      if (owner >= 0) begin
        exp_grant[owner] = 1'b1;
        if (pres[owner]) begin
          exp_rdy        = 1'b1;
          exp_data       = q_data[owner][0];
          exp_eof        = q_eof[owner][0];
          exp_ack[owner] = tx_ack;
        end
      end
      checks++;
      if ({grant, busy, tx_rdy, tx_eof, tx_data, src_ack} !==
          {exp_grant, exp_busy, exp_rdy, exp_eof, exp_data, exp_ack}) begin
        errors++;
        $display("FAIL random_cycle%0d: grant=%b busy=%b rdy=%b eof=%b data=%h ack=%b, expected %b %b %b %b %h %b",
                 cyc, grant, busy, tx_rdy, tx_eof, tx_data, src_ack,
                 exp_grant, exp_busy, exp_rdy, exp_eof, exp_data, exp_ack);
      end
      // Reference: round-robin choice when idle, frame release on an acknowledged eof.
      if (owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (!found && pres[j]) begin
            found = 1'b1;
            owner = j;
          end
        end
      end else if (exp_rdy && tx_ack) begin
        eof_now = q_eof[owner][0];
        void'(q_data[owner].pop_front());
        void'(q_eof[owner].pop_front());
        pres[owner] = 1'b0;
        gap[owner]  = int'($urandom_range(0, 2));
        if (eof_now) begin
          ptr   = (owner + 1) % N;
          owner = -1;
        end
      end
      pending = (owner >= 0);
      for (int i = 0; i < N; i++) if (q_data[i].size() > 0) pending = 1'b1;
      tick();
    end
    idle_inputs();
    checks++;
    if (pending) begin
      errors++;
      $display("FAIL random_drain: frames still pending=%b, expected 0", pending);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_stall();
    test_reset_mid();
`ifdef TX_FRAME_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
